// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA raster timing constants.
//   - 640x480@60 default timing (25 MHz pixel clock from a 50 MHz system clock)
//   - 800x600@60 alternate timing set
//   - vga_total(): line/frame length from active + porches + sync
//   - SYNC_ACTIVE: level driven on hsync_n/vsync_n during a sync pulse
package vga_pkg;

  function automatic int unsigned vga_total(input int unsigned active,
                                            input int unsigned fp,
                                            input int unsigned sync,
                                            input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned VGA_CNT_W    = 10;
  localparam int unsigned VGA_CLK_DIV  = 2;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned VGA_H_TOTAL =
    vga_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
  localparam int unsigned VGA_V_TOTAL =
    vga_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

  localparam int unsigned SVGA_H_ACTIVE = 800;
  localparam int unsigned SVGA_H_FP     = 40;
  localparam int unsigned SVGA_H_SYNC   = 128;
  localparam int unsigned SVGA_H_BP     = 88;
  localparam int unsigned SVGA_V_ACTIVE = 600;
  localparam int unsigned SVGA_V_FP     = 1;
  localparam int unsigned SVGA_V_SYNC   = 4;
  localparam int unsigned SVGA_V_BP     = 23;

  // Both sync outputs are active low.
  localparam logic SYNC_ACTIVE = 1'b0;

endpackage

// File: rtl/vga_timing_controller_comparator.sv
// comparator: unsigned less-than between a counter value and a threshold.
//   a_i   in  N  counter value
//   b_i   in  N  threshold
//   lt_o  out 1  a_i < b_i
module comparator #(
  parameter int unsigned N = 10
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         lt_o
);

  assign lt_o = (a_i < b_i);

endmodule

// File: rtl/vga_timing_controller.sv
// vga_timing_controller: VGA raster sequencer.
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active high (priority over en)
//   en           in   run enable; 0 freezes divider, counters and outputs
//   pixel_tick   out  1-clk pulse once per CLK_DIV clocks
//   hsync_n      out  horizontal sync, active low
//   vsync_n      out  vertical sync, active low
//   video_on     out  (x, y) inside the visible area
//   x, y         out  current raster position
//   frame_start  out  1-clk pulse when x=0, y=0 appears after a frame wrap
module vga_timing_controller
  import vga_pkg::*;
#(
  parameter int unsigned CNT_W    = VGA_CNT_W,
  parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             pixel_tick,
  output logic             hsync_n,
  output logic             vsync_n,
  output logic             video_on,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

  // Sync windows are [start, end) so each needs only less-than compares.
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS_C   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE_C   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SS_C   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE_C   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  if ((longint'(H_TOTAL) > (longint'(1) << CNT_W)) ||
      (longint'(V_TOTAL) > (longint'(1) << CNT_W))) begin : g_width_err
    $error("vga_timing_controller: CNT_W too narrow for H_TOTAL-1 / V_TOTAL-1");
  end

  if (CLK_DIV == 0) begin : g_div_err
    $error("vga_timing_controller: CLK_DIV must be at least 1");
  end

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             frame_wrap_q, frame_wrap_d;

  logic             pixel_tick_q, hsync_n_q, vsync_n_q, video_on_q, frame_start_q;
  logic [CNT_W-1:0] x_q, y_q;

  logic div_wrap, h_last, v_last;
  logic h_lt_act, h_lt_ss, h_lt_se;
  logic v_lt_act, v_lt_ss, v_lt_se;
  logic hs, vs, vis;

  comparator #(.N(CNT_W)) u_h_act (.a_i(h_cnt_q), .b_i(H_ACT_C), .lt_o(h_lt_act));
  comparator #(.N(CNT_W)) u_h_ss  (.a_i(h_cnt_q), .b_i(H_SS_C),  .lt_o(h_lt_ss));
  comparator #(.N(CNT_W)) u_h_se  (.a_i(h_cnt_q), .b_i(H_SE_C),  .lt_o(h_lt_se));
  comparator #(.N(CNT_W)) u_v_act (.a_i(v_cnt_q), .b_i(V_ACT_C), .lt_o(v_lt_act));
  comparator #(.N(CNT_W)) u_v_ss  (.a_i(v_cnt_q), .b_i(V_SS_C),  .lt_o(v_lt_ss));
  comparator #(.N(CNT_W)) u_v_se  (.a_i(v_cnt_q), .b_i(V_SE_C),  .lt_o(v_lt_se));

  assign hs  = !h_lt_ss && h_lt_se;
  assign vs  = !v_lt_ss && v_lt_se;
  assign vis = h_lt_act && v_lt_act;

  always_comb begin
    div_wrap     = en && (div_cnt_q == DIV_LAST);
    h_last       = (h_cnt_q == H_LAST);
    v_last       = (v_cnt_q == V_LAST);
    div_cnt_d    = div_cnt_q;
    h_cnt_d      = h_cnt_q;
    v_cnt_d      = v_cnt_q;
    frame_wrap_d = frame_wrap_q;

    if (en) begin
      div_cnt_d    = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
      // Remembers the frame wrap until the outputs have shown (0,0) once,
      // so frame_start stays aligned with x/y even across an en=0 gap.
      frame_wrap_d = div_wrap && h_last && v_last;
    end

    if (div_wrap) begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + CNT_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      frame_wrap_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      frame_wrap_q <= frame_wrap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_tick_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hsync_n_q     <= ~SYNC_ACTIVE;
      vsync_n_q     <= ~SYNC_ACTIVE;
      video_on_q    <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
    end else if (en) begin
      pixel_tick_q  <= div_wrap;
      frame_start_q <= frame_wrap_q;
      hsync_n_q     <= hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_n_q     <= vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      video_on_q    <= vis;
      x_q           <= h_cnt_q;
      y_q           <= v_cnt_q;
    end else begin
      pixel_tick_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign pixel_tick  = pixel_tick_q;
  assign frame_start = frame_start_q;
  assign hsync_n     = hsync_n_q;
  assign vsync_n     = vsync_n_q;
  assign video_on    = video_on_q;
  assign x           = x_q;
  assign y           = y_q;

endmodule
